// File: rtl/rec_ctrl_pkg.sv
// Shared types for the recurrence controller: FSM states, strobe vector, size defaults.
package rec_ctrl_pkg;

    localparam int unsigned SIZE_DEF      = 4;
    localparam int unsigned MAX_ENTRY_DEF = 14;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        EVAL,
        PUSH,
        PUSH_ACK,
        CALC,
        CALC_ACK,
        CHECK,
        POP,
        RESUPD,
        FINISH
    } state_t;

    // Fixed bit order, MSB first: load_init, alu, updater, cal_res, poping, res_updater
    typedef struct packed {
        logic load_init;
        logic alu;
        logic updater;
        logic cal_res;
        logic poping;
        logic res_updater;
    } strobe_t;

endpackage

// File: rtl/rec_ctrl_cnt.sv
// Saturating busy-cycle counter with synchronous clear and count enable.
module rec_ctrl_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rec_ctrl.sv
// Sequencing FSM for the stack-based recurrence datapath (value[n] = 2*value[n-1] + 3*value[n-2]).
// Optional busy-cycle watchdog enabled by defining REC_CTRL_WATCHDOG_EN.
module rec_ctrl
    import rec_ctrl_pkg::*;
#(
    parameter int unsigned SIZE       = SIZE_DEF,
    parameter int unsigned MAX_ENTRY  = MAX_ENTRY_DEF,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MAX_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIZE-1:0]   entry,
    output logic              ready,
    output logic [SIZE-1:0]   dp_entry,
    output logic              load_init,
    output logic              alu,
    output logic              updater,
    output logic              cal_res,
    output logic              poping,
    output logic              res_updater,
    input  logic              dp_updated,
    input  logic              dp_cal_update,
    input  logic              dp_backtrack,
    input  logic              dp_done,
    input  logic [2*SIZE-1:0] dp_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*SIZE-1:0] result,
    output logic [CNT_W-1:0]  cycles,
    output logic              err
);

    if (MAX_CYCLES == 0 || MAX_ENTRY >= (1 << SIZE)) begin : g_cfg_check
        $error("rec_ctrl: illegal parameterisation");
    end

    state_t           state, state_nxt;
    strobe_t          strb;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             bad_entry;
    logic             busy;
    logic             timeout;

    assign accept    = (state == IDLE) && start;
    assign bad_entry = 32'(entry) > MAX_ENTRY;
    assign busy      = (state != IDLE) && (state != FINISH);
    assign ready     = (state == IDLE);

`ifdef REC_CTRL_WATCHDOG_EN
    assign timeout = busy && (count >= CNT_W'(MAX_CYCLES));
`else
    assign timeout = 1'b0;
`endif

    // Counter freezes on the timeout cycle so the reported count equals the limit
    rec_ctrl_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .en    (busy && !timeout),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        strb      = '0;
        unique case (state)
            IDLE:     if (start) state_nxt = bad_entry ? FINISH : INIT;
            INIT: begin
                strb.load_init = 1'b1;
                state_nxt      = EVAL;
            end
            EVAL: begin
                strb.alu = 1'b1;
                if (dp_done)           state_nxt = FINISH;
                else if (dp_backtrack) state_nxt = CALC;
                else                   state_nxt = PUSH;
            end
            PUSH: begin
                strb.updater = 1'b1;
                state_nxt    = PUSH_ACK;
            end
            PUSH_ACK: if (dp_updated) state_nxt = EVAL;
            CALC: begin
                strb.cal_res = 1'b1;
                state_nxt    = CALC_ACK;
            end
            CALC_ACK: if (dp_cal_update) state_nxt = CHECK;
            CHECK:    state_nxt = dp_done ? FINISH : POP;
            POP: begin
                strb.poping = 1'b1;
                state_nxt   = RESUPD;
            end
            RESUPD: begin
                strb.res_updater = 1'b1;
                state_nxt        = EVAL;
            end
            FINISH:   if (out_valid && out_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        if (timeout) begin
            state_nxt = FINISH;
            strb      = '0;
        end
    end

    assign load_init   = strb.load_init;
    assign alu         = strb.alu;
    assign updater     = strb.updater;
    assign cal_res     = strb.cal_res;
    assign poping      = strb.poping;
    assign res_updater = strb.res_updater;

    // First FINISH cycle is the one with out_valid still low: capture there
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dp_entry  <= '0;
            result    <= '0;
            cycles    <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                dp_entry <= entry;
                err      <= bad_entry;
            end
            if (timeout) begin
                err <= 1'b1;
            end
            if (state == FINISH) begin
                if (!out_valid) begin
                    result    <= err ? '0 : dp_result;
                    cycles    <= count;
                    out_valid <= 1'b1;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rec_ctrl.sv
// Bench for rec_ctrl: behavioural stack datapath stub plus arithmetic reference of result, cycles and latency.
module tb_rec_ctrl;

    localparam int MAXC = 20;
`ifdef REC_CTRL_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  entry;
    logic        ready;
    logic [3:0]  dp_entry;
    logic        load_init, alu, updater, cal_res, poping, res_updater;
    logic        dp_updated, dp_cal_update, dp_backtrack, dp_done;
    logic [7:0]  dp_result;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  result;
    logic [15:0] cycles;
    logic        err;
    logic [5:0]  sv_now;

    assign sv_now = {load_init, alu, updater, cal_res, poping, res_updater};

    always #5 clk = ~clk;

    rec_ctrl #(
        .SIZE       (4),
        .MAX_ENTRY  (14),
        .CNT_W      (16),
        .MAX_CYCLES (MAXC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .entry         (entry),
        .ready         (ready),
        .dp_entry      (dp_entry),
        .load_init     (load_init),
        .alu           (alu),
        .updater       (updater),
        .cal_res       (cal_res),
        .poping        (poping),
        .res_updater   (res_updater),
        .dp_updated    (dp_updated),
        .dp_cal_update (dp_cal_update),
        .dp_backtrack  (dp_backtrack),
        .dp_done       (dp_done),
        .dp_result     (dp_result),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .cycles        (cycles),
        .err           (err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_val(input int n);
        int unsigned v [0:15];
        v[0] = 1;
        v[1] = 1;
        for (int i = 2; i <= n; i++) v[i] = (2 * v[i-1] + 3 * v[i-2]) % 256;
        return 8'(v[n]);
    endfunction

    // n-1 descents, n-1 ascents; ack waits add du/dc cycles each
    function automatic int busy_cycles(input int n, input int du, input int dc);
        if (n <= 1) return 2;
        return 1 + 2*(n-1) + (n-1)*(du+2) + (n-1)*(dc+3) + 2*(n-2);
    endfunction

    // Datapath stub: explicit stack walk, acks after configurable delays
    int          upd_cfg = 0, cal_cfg = 0;
    bit          cal_stuck = 1'b0;
    int          target, cidx, sp, wu, wc;
    logic [7:0]  va, vb, res;
    bit          loaded, pend_u, pend_c, top_done, exp_alu;
    int          multi_bad = 0, seq_bad = 0, strobe_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            loaded = 0; pend_u = 0; pend_c = 0; top_done = 0; exp_alu = 0;
            dp_updated = 0; dp_cal_update = 0; dp_done = 0; dp_backtrack = 0; dp_result = '0;
        end else begin
            if ($countones(sv_now) > 1) multi_bad++;
            if (sv_now != 0) strobe_cnt++;
            if (load_init) begin
                target = int'(dp_entry); cidx = target; sp = 0;
                va = 8'd1; vb = 8'd1; res = 8'd1;
                loaded = 1; top_done = 0; pend_u = 0; pend_c = 0;
                dp_updated = 0; dp_cal_update = 0;
            end
            if (exp_alu) begin
                if (!alu) seq_bad++;
                exp_alu = 0;
            end
            if (pend_u && !dp_updated && !updater && sv_now != 0) seq_bad++;
            if (alu) begin
                pend_u = 0;
                dp_updated = 0;
            end
            if (updater) begin
                sp++; cidx--; pend_u = 1; wu = upd_cfg;
            end else if (pend_u && !dp_updated) begin
                if (wu == 0) begin
                    dp_updated = 1;
                    exp_alu = 1;
                end else wu--;
            end
            if (cal_res) begin
                res = 8'(2 * vb + 3 * va);
                pend_c = 1; wc = cal_cfg;
                if (sp == 1) top_done = 1;
            end else if (pend_c && !dp_cal_update && !cal_stuck) begin
                if (wc == 0) dp_cal_update = 1;
                else wc--;
            end
            if (poping) begin
                sp--; pend_c = 0; dp_cal_update = 0;
            end
            if (res_updater) begin
                va = vb; vb = res;
            end
            dp_done      = loaded && (target <= 1 || top_done);
            dp_backtrack = loaded && (cidx <= 1);
            dp_result    = res;
        end
    end

    task automatic do_job(input int e, input int du, input int dc, input int hold,
                          input bit early, input bit poke, input bit stuck);
        int lat, k, m0, s0, q0, cn, ecyc, elat, estr, unstable;
        bit bad, to;
        logic [7:0]  eres, r0;
        logic [15:0] c0;
        logic        e0;
        bad  = e > 14;
        cn   = bad ? 0 : (stuck ? 100000 : busy_cycles(e, du, dc));
        to   = WD && !bad && cn > MAXC;
        ecyc = to ? MAXC : cn;
        elat = to ? MAXC + 3 : cn + 2;
        eres = (bad || to) ? 8'd0 : ref_val(e);
        estr = bad ? 0 : (e <= 1 ? 2 : 1 + 4*(e-1) + 2*(e-2));
        upd_cfg = du; cal_cfg = dc; cal_stuck = stuck;
        k = 0;
        while (!ready && k < 50) begin @(negedge clk); k++; end
        chk("idle_ready", 32'(ready), 1);
        m0 = multi_bad; s0 = strobe_cnt; q0 = seq_bad;
        out_ready = early; start = 1'b1; entry = 4'(e);
        @(negedge clk);
        start = 1'b0; lat = 1;
        while (!out_valid && lat < 3000) begin
            if (poke && lat == 3) begin start = 1'b1; entry = 4'(e ^ 5); end
            else start = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0; out_ready = 1'b0;
        chk("latency", lat, elat);
        chk("result", 32'(result), 32'(eres));
        chk("err", 32'(err), 32'(bad || to));
        chk("cycles", 32'(cycles), ecyc);
        if (poke) chk("dp_entry", 32'(dp_entry), e);
        r0 = result; c0 = cycles; e0 = err; unstable = 0;
        repeat (hold) begin
            @(negedge clk);
            if (!out_valid || result !== r0 || cycles !== c0 || err !== e0) unstable++;
        end
        chk("hold_stable", unstable, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", 32'(out_valid), 0);
        chk("ready_back", 32'(ready), 1);
        chk("onehot", multi_bad - m0, 0);
        if (!to) begin
            chk("seq", seq_bad - q0, 0);
            chk("strobes", strobe_cnt - s0, estr);
        end
        cal_stuck = 1'b0;
    endtask

    initial begin
        int k;
        rst = 1'b0; start = 1'b0; entry = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_strobes", 32'(sv_now), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_cycles", 32'(cycles), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_dp_entry", 32'(dp_entry), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 1);

        do_job(1, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        do_job(15, 0, 0, 2, 1'b0, 1'b0, 1'b0);
        do_job(0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        do_job(4, 0, 0, 3, 1'b1, 1'b1, 1'b0);
        do_job(2, 5, 0, 0, 1'b0, 1'b0, 1'b0);

        upd_cfg = 6; cal_cfg = 0;
        start = 1'b1; entry = 4'd5;
        @(negedge clk);
        start = 1'b0; k = 0;
        while (!updater && k < 50) begin @(negedge clk); k++; end
        @(negedge clk);
        chk("pa_quiet", 32'(sv_now), 0);
        rst = 1'b0;
        #1;
        chk("midrst_ready", 32'(ready), 1);
        chk("midrst_strobes", 32'(sv_now), 0);
        chk("midrst_valid", 32'(out_valid), 0);
        @(negedge clk);
        rst = 1'b1;
        do_job(3, 0, 1, 2, 1'b0, 1'b0, 1'b0);

        do_job(14, 1, 2, 1, 1'b0, 1'b1, 1'b0);
`ifdef REC_CTRL_WATCHDOG_EN
        do_job(3, 0, 0, 4, 1'b0, 1'b0, 1'b1);
`endif

        for (int i = 0; i < 30; i++) begin
            do_job(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
